// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: issues sequential word fetches to a variable
// latency instruction memory, buffers returns in order and hands them to the
// core over a valid/ready handshake. A redirect flushes the queue and marks
// every return still owed as stale so it is discarded on arrival.
module fetch_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        mem_req_valid,
    output logic [63:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    output logic        inst_valid,
    output logic [31:0] inst_data,
    output logic [63:0] inst_pc,
    input  logic        inst_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    // Stale returns owed are bounded by how many requests the memory can hold
    // in flight, not by DEPTH, because the credit check ignores drop. Eight
    // bits covers memories with up to 255 cycles of latency.
    localparam int DW = 8;

    logic [63:0]   fetch_pc;
    logic [63:0]   tail_pc;
    logic [63:0]   q_pc    [DEPTH];
    logic [31:0]   q_instr [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [DW-1:0] drop;

    logic          accept;
    logic          push;
    logic          pop;
    logic          rsp_drop;
    logic [CW:0]   credit_used;
    logic [PW-1:0] rd_next;
    logic [CW-1:0] count_after_pop;
    logic          head_load;
    logic [63:0]   head_pc;
    logic [31:0]   head_instr;
    logic [1:0]    unused_redirect_low;

    assign unused_redirect_low = redirect_pc[1:0];

    // Credit is taken from registered state only, never from mem_req_ready.
    assign credit_used   = {1'b0, count} + {1'b0, outstanding};
    assign mem_req_valid = !rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
    assign mem_req_addr  = rst ? RESET_PC : fetch_pc;
    assign accept        = mem_req_valid && mem_req_ready;

    assign rsp_drop   = mem_rsp_valid && (drop != '0);
    assign push       = mem_rsp_valid && (drop == '0) && !redirect_valid;
    assign inst_valid = !rst && (count != '0);
    assign pop        = inst_valid && inst_ready;

    assign rd_next         = pop ? rd_ptr + 1'b1 : rd_ptr;
    assign count_after_pop = count - CW'(pop);

    // Select the entry that will sit at the head next cycle, if any.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        head_load  = 1'b0;
        head_pc    = inst_pc;
        head_instr = inst_data;
        if (!redirect_valid) begin
            if (count_after_pop != '0) begin
                head_load  = 1'b1;
                head_pc    = q_pc[rd_next];
                head_instr = q_instr[rd_next];
            end else if (push) begin
                head_load  = 1'b1;
                head_pc    = tail_pc;
                head_instr = mem_rsp_data;
            end
        end
    end

    // Queue storage write; pointers and count are what make an entry valid.
    always_ff @(posedge clk) begin
        // NOTE: the storage array is deliberately not reset; occupancy
        // guards it, and leaving it out keeps it a plain RAM.
        if (push) begin
            q_pc[wr_ptr]    <= tail_pc;
            q_instr[wr_ptr] <= mem_rsp_data;
        end
    end

    // Control state: fetch address, pointers, counters and the head register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of its neighbours.
        if (rst) begin
            fetch_pc    <= RESET_PC;
            tail_pc     <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            drop        <= '0;
            inst_data   <= '0;
            inst_pc     <= '0;
        end else begin
            if (head_load) begin
                inst_pc   <= head_pc;
                inst_data <= head_instr;
            end
            if (redirect_valid) begin
                fetch_pc    <= {redirect_pc[63:2], 2'b00};
                tail_pc     <= {redirect_pc[63:2], 2'b00};
                rd_ptr      <= '0;
                wr_ptr      <= '0;
                count       <= '0;
                outstanding <= '0;
                // Everything still owed, minus a return landing right now.
                drop        <= drop + DW'(outstanding) - DW'(mem_rsp_valid);
            end else begin
                if (accept) begin
                    fetch_pc <= fetch_pc + 64'd4;
                end
                if (push) begin
                    wr_ptr  <= wr_ptr + 1'b1;
                    tail_pc <= tail_pc + 64'd4;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count       <= count + CW'(push) - CW'(pop);
                outstanding <= outstanding + CW'(accept) - CW'(push);
                if (rsp_drop) begin
                    drop <= drop - 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// Scoreboard bench for fetch_prefetch_queue: a randomized latency memory model,
// a driver for core/redirect stimulus, and a monitor that checks the
// instruction stream against "last redirect target plus 4*n".
module tb_fetch_prefetch_queue;

    localparam int          DEPTH    = 4;
    localparam logic [63:0] RESET_PC = 64'h0;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        mem_req_valid;
    logic [63:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [63:0] inst_pc;
    logic        inst_ready;

    fetch_prefetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req_valid  (mem_req_valid),
        .mem_req_addr   (mem_req_addr),
        .mem_req_ready  (mem_req_ready),
        .mem_rsp_valid  (mem_rsp_valid),
        .mem_rsp_data   (mem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_data      (inst_data),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Contents of the instruction memory at a given address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ {a[15:0], a[31:16]} ^ 32'h5A5A_0F0F;
    endfunction

    // Stimulus knobs.
    int          lat_min  = 1;
    int          lat_max  = 1;
    int          rdy_pct  = 100;
    int          ir_pct   = 100;
    int          redir_pm = 0;
    bit          force_redir = 1'b0;
    logic [63:0] force_pc = '0;
    bit          running = 1'b0;
    longint      cyc = 0;

    // Reference model of the expected instruction stream.
    logic [63:0] exp_q[$];
    logic [63:0] gen_pc;
    logic [63:0] req_exp;
    int          issued_since = 0;
    int          popped_since = 0;
    int          total_pops = 0;
    bit          prev_redirect = 1'b0;

    task automatic restart_model(input logic [63:0] target);
        exp_q.delete();
        gen_pc       = {target[63:2], 2'b00};
        req_exp      = gen_pc;
        issued_since = 0;
        popped_since = 0;
    endtask

    task automatic refill();
        while (exp_q.size() < 16) begin
            exp_q.push_back(gen_pc);
            gen_pc += 64'd4;
        end
    endtask

    // Memory model and input driver.
    typedef struct {
        logic [63:0] addr;
        longint      due;
    } mem_req_t;
    mem_req_t mem_q[$];

    initial begin : driver
        longint   due;
        longint   last_due;
        mem_req_t r;
        last_due = 0;
        forever begin
            @(negedge clk);
            if (running) begin
                if (mem_req_valid && mem_req_ready) begin
                    due = cyc + longint'($urandom_range(lat_max, lat_min));
                    if (due < last_due) due = last_due;
                    last_due = due;
                    r.addr = mem_req_addr;
                    r.due  = due;
                    mem_q.push_back(r);
                end
                if (mem_rsp_valid) void'(mem_q.pop_front());
            end
            @(posedge clk);
            cyc++;
            #1;
            if (running) begin
                mem_req_ready = ($urandom_range(99, 0) < rdy_pct);
                inst_ready    = ($urandom_range(99, 0) < ir_pct);
                if (force_redir) begin
                    redirect_valid = 1'b1;
                    redirect_pc    = force_pc;
                    force_redir    = 1'b0;
                end else if ($urandom_range(999, 0) < redir_pm) begin
                    redirect_valid = 1'b1;
                    if ($urandom_range(3, 0) == 0)
                        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15, 0));
                    else
                        redirect_pc = {$urandom(), $urandom()};
                end else begin
                    redirect_valid = 1'b0;
                end
                if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = mem_word(mem_q[0].addr);
                end else begin
                    mem_rsp_valid = 1'b0;
                    mem_rsp_data  = $urandom();
                end
            end
        end
    end

    // Monitor: compares pops and requests against the model each cycle.
    initial begin : monitor
        logic [63:0] exp_pc;
        forever begin
            @(negedge clk);
            if (running) begin
                if (prev_redirect) check("empty_after_redirect", inst_valid, 1'b0);
                if (redirect_valid) check("no_req_in_redirect", mem_req_valid, 1'b0);
                if (inst_valid && inst_ready) begin
                    exp_pc = exp_q.pop_front();
                    check("inst_pc", inst_pc, exp_pc);
                    check("inst_data", inst_data, mem_word(exp_pc));
                    popped_since++;
                    total_pops++;
                end
                if (mem_req_valid && mem_req_ready) begin
                    check("req_addr", mem_req_addr, req_exp);
                    req_exp += 64'd4;
                    issued_since++;
                    check("credit_limit", (issued_since - popped_since) <= DEPTH, 1'b1);
                end
                prev_redirect = redirect_valid;
                if (redirect_valid) restart_model(redirect_pc);
                refill();
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    initial begin : main
        int p0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_req_ready  = 1'b0;
        mem_rsp_valid  = 1'b0;
        mem_rsp_data   = '0;
        inst_ready     = 1'b0;

        @(negedge clk);
        check("rst_req_valid", mem_req_valid, 1'b0);
        check("rst_req_addr", mem_req_addr, RESET_PC);
        check("rst_inst_valid", inst_valid, 1'b0);
        @(negedge clk);
        check("rst_inst_data", inst_data, 32'h0);
        check("rst_inst_pc", inst_pc, 64'h0);

        @(posedge clk);
        #1;
        restart_model(RESET_PC);
        refill();
        mem_req_ready = 1'b1;
        inst_ready    = 1'b1;
        rst           = 1'b0;
        running       = 1'b1;
        @(negedge clk);
        check("first_req_valid", mem_req_valid, 1'b1);

        // Streaming: latency 1, always ready, one instruction per cycle.
        wait_cycles(6);
        p0 = total_pops;
        wait_cycles(20);
        check("throughput", 64'(total_pops - p0), 64'd20);

        // Core stalled: exactly DEPTH requests, then drain and resume.
        ir_pct      = 0;
        force_pc    = 64'h0;
        force_redir = 1'b1;
        wait_cycles(25);
        check("fill_issued", 64'(issued_since), 64'(DEPTH));
        check("fill_stall", mem_req_valid, 1'b0);
        check("fill_head_valid", inst_valid, 1'b1);
        check("fill_head_pc", inst_pc, 64'h0);
        ir_pct = 100;
        wait_cycles(15);
        check("drain_progress", popped_since >= 8, 1'b1);

        // Latency 3 with requests in flight, redirect to an unaligned target.
        lat_min = 3;
        lat_max = 3;
        wait_cycles(12);
        force_pc    = 64'h1002;
        force_redir = 1'b1;
        wait_cycles(20);
        check("redirect_progress", popped_since > 5, 1'b1);

        // Address wrap past the top of the address space.
        lat_min     = 1;
        lat_max     = 1;
        force_pc    = 64'hFFFF_FFFF_FFFF_FFF4;
        force_redir = 1'b1;
        wait_cycles(15);
        check("wrap_progress", popped_since >= 5, 1'b1);

        // Random readiness, latency and redirects.
        lat_min  = 1;
        lat_max  = 5;
        rdy_pct  = 70;
        ir_pct   = 70;
        redir_pm = 30;
        p0 = total_pops;
        wait_cycles(3000);
        check("random_progress", (total_pops - p0) > 300, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
